// File: rtl/glitch_sequencer_if.sv
// Control/config/status bundle between a glitch controller and glitch_sequencer.
interface glitch_sequencer_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned NUM_W = 8
);
  logic             arm;
  logic             free_run;
  logic             abort;
  logic             trig_in;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_period;
  logic [NUM_W-1:0] cfg_count;
  logic             glitch_out;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output arm, free_run, abort, trig_in,
    output cfg_delay, cfg_width, cfg_gap, cfg_period, cfg_count,
    input  glitch_out, busy, done, pulse_cnt
  );

  modport slave (
    input  arm, free_run, abort, trig_in,
    input  cfg_delay, cfg_width, cfg_gap, cfg_period, cfg_count,
    output glitch_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/glitch_sequencer.sv
// Programmable glitch burst generator: delay / width / gap / count / period,
// launched by a synchronised trigger edge (single-shot) or autonomously (free-run).
module glitch_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned NUM_W       = 8,
  parameter int unsigned ACTIVE_HIGH = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  glitch_sequencer_if.slave bus
);

  localparam logic IDLE_LVL = (ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP, S_END, S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_W-1:0]       pcnt_q, pcnt_d;
  logic                   glitch_q, glitch_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   latch;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev_q;
  logic                   trig_rise_q;

  logic [CNT_W-1:0]       sh_delay, sh_width, sh_gap, sh_period;
  logic [NUM_W-1:0]       sh_count;
  logic                   sh_free;

  // Down-counter load value for an N-cycle stay where 0 is treated as 1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Trigger synchroniser and registered rising-edge detector, running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      trig_rise_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.trig_in};
      trig_prev_q <= sync_q[SYNC_STAGES-1];
      trig_rise_q <= sync_q[SYNC_STAGES-1] & ~trig_prev_q;
    end
  end

  // Shadow configuration, captured only at the arm point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_delay  <= '0;
      sh_width  <= '0;
      sh_gap    <= '0;
      sh_period <= '0;
      sh_count  <= '0;
      sh_free   <= 1'b0;
    end else if (latch) begin
      sh_delay  <= bus.cfg_delay;
      sh_width  <= bus.cfg_width;
      sh_gap    <= bus.cfg_gap;
      sh_period <= bus.cfg_period;
      sh_count  <= bus.cfg_count;
      sh_free   <= bus.free_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      glitch_q <= IDLE_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      glitch_q <= glitch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state; outputs are registered from the next state so they align with it.
  // Free-run always passes through DELAY for at least one cycle, even with delay 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    latch   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          latch = 1'b1;
          if (bus.free_run) begin
            state_d = S_DELAY;
            cnt_d   = len_m1(bus.cfg_delay);
            pcnt_d  = '0;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (trig_rise_q) begin
          pcnt_d = '0;
          if (sh_delay != '0) begin
            state_d = S_DELAY;
            cnt_d   = sh_delay - CNT_W'(1);
          end else if (sh_count != '0) begin
            state_d = S_PULSE;
            cnt_d   = len_m1(sh_width);
          end else begin
            state_d = S_END;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (sh_count != '0) begin
          state_d = S_PULSE;
          cnt_d   = len_m1(sh_width);
        end else begin
          state_d = S_END;
        end
      end
      S_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pcnt_d = pcnt_q + NUM_W'(1);
          if (({1'b0, pcnt_q} + (NUM_W+1)'(1)) < {1'b0, sh_count}) begin
            state_d = S_GAP;
            cnt_d   = len_m1(sh_gap);
          end else begin
            state_d = S_END;
          end
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_PULSE;
          cnt_d   = len_m1(sh_width);
        end
      end
      S_END: begin
        if (sh_free) begin
          state_d = S_HOLD;
          cnt_d   = len_m1(sh_period);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DELAY;
          cnt_d   = len_m1(sh_delay);
          pcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle arm; pulse count is frozen.
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pcnt_d  = pcnt_q;
      latch   = 1'b0;
    end

    glitch_d = (state_d == S_PULSE) ? ~IDLE_LVL : IDLE_LVL;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_END);
  end

  assign bus.glitch_out = glitch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulse_cnt  = pcnt_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: vector table, hand-written corner
// sequences and randomised bursts against an arithmetic timeline model.
`timescale 1ns/1ps
module tb_glitch_sequencer;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned NUM_W = 8;
  localparam int unsigned SYNC  = 2;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  int     mirror_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glitch_sequencer_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();
  glitch_sequencer_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus_n ();

  glitch_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W), .ACTIVE_HIGH(1), .SYNC_STAGES(SYNC))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  glitch_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W), .ACTIVE_HIGH(0), .SYNC_STAGES(SYNC))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

  assign bus_n.arm        = bus.arm;
  assign bus_n.free_run   = bus.free_run;
  assign bus_n.abort      = bus.abort;
  assign bus_n.trig_in    = bus.trig_in;
  assign bus_n.cfg_delay  = bus.cfg_delay;
  assign bus_n.cfg_width  = bus.cfg_width;
  assign bus_n.cfg_gap    = bus.cfg_gap;
  assign bus_n.cfg_period = bus.cfg_period;
  assign bus_n.cfg_count  = bus.cfg_count;

  // The inverted build must be the exact complement on glitch_out and identical elsewhere.
  always @(negedge clk)
    if (bus_n.glitch_out !== ~bus.glitch_out || bus_n.busy !== bus.busy ||
        bus_n.done !== bus.done || bus_n.pulse_cnt !== bus.pulse_cnt)
      mirror_err <= mirror_err + 1;

  typedef struct {
    logic   out;
    logic   done;
    logic   busy;
    longint pcnt;
    bit     pcnt_valid;
  } exp_t;

  typedef struct {
    int d, w, g, n;
    int exp_first, exp_active, exp_done_at, exp_pcnt;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint burst_len(input longint w, input longint g, input longint n);
    longint wd = (w == 0) ? 1 : w;
    longint gd = (g == 0) ? 1 : g;
    return (n == 0) ? 0 : n * wd + (n - 1) * gd;
  endfunction

  // Expected outputs j cycles after the burst origin (first cycle after trig_rise,
  // or first cycle after the arm edge in free-run).
  function automatic exp_t model(input longint j, input longint d, input longint w,
                                 input longint g, input longint n, input longint p,
                                 input bit free);
    exp_t   e;
    longint wd, gd, pd, dd, len, jj, q;
    e  = '{out: 1'b0, done: 1'b0, busy: 1'b1, pcnt: 0, pcnt_valid: 1'b1};
    wd = (w == 0) ? 1 : w;
    gd = (g == 0) ? 1 : g;
    pd = (p == 0) ? 1 : p;
    dd = (free && d == 0) ? 1 : d;
    len = burst_len(w, g, n);
    if (j < 0) begin
      e.pcnt_valid = 1'b0;
      return e;
    end
    jj = j;
    if (free) jj = j % (dd + len + 1 + pd);
    else if (j > dd + len) begin
      e.busy = 1'b0;
      e.pcnt = n;
      return e;
    end
    if (jj < dd) e.pcnt = 0;
    else if (jj < dd + len) begin
      q = jj - dd;
      e.out  = ((q % (wd + gd)) < wd);
      e.pcnt = q / (wd + gd) + (((q % (wd + gd)) >= wd) ? 1 : 0);
    end else begin
      e.pcnt = n;
      e.done = (jj == dd + len);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.abort = 1'b1;
    tick();
    bus.abort   = 1'b0;
    bus.arm     = 1'b0;
    bus.trig_in = 1'b0;
    repeat (SYNC + 3) tick();
  endtask

  task automatic arm_cfg(input longint d, input longint w, input longint g,
                         input longint n, input longint p, input bit free);
    bus.cfg_delay  = CNT_W'(d);
    bus.cfg_width  = CNT_W'(w);
    bus.cfg_gap    = CNT_W'(g);
    bus.cfg_count  = NUM_W'(n);
    bus.cfg_period = CNT_W'(p);
    bus.free_run   = free;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic check_window(input string name, input longint o, input longint d,
                              input longint w, input longint g, input longint n,
                              input longint p, input bit free, input int ncyc);
    exp_t  e;
    bit    bad = 1'b0;
    string msg = "";
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      e = model(cyc - o, d, w, g, n, p, free);
      if (!bad && (bus.glitch_out !== e.out || bus.done !== e.done || bus.busy !== e.busy ||
                   (e.pcnt_valid && bus.pulse_cnt !== NUM_W'(e.pcnt)))) begin
        bad = 1'b1;
        msg = $sformatf("at j=%0d out/done/busy/pcnt got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                        cyc - o, bus.glitch_out, bus.done, bus.busy, bus.pulse_cnt,
                        e.out, e.done, e.busy, e.pcnt);
      end
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  task automatic run_single(input string name, input longint d, input longint w,
                            input longint g, input longint n);
    longint o;
    go_idle();
    arm_cfg(d, w, g, n, 0, 1'b0);
    repeat (2) tick();
    bus.trig_in = 1'b1;
    o = cyc + SYNC + 2;
    check_window(name, o, d, w, g, n, 0, 1'b0, int'(SYNC + 2 + d + burst_len(w, g, n) + 4));
  endtask

  task automatic count_quiet(input int ncyc, output int active, output int dones, output int busys);
    active = 0; dones = 0; busys = 0;
    repeat (ncyc) begin
      @(negedge clk);
      active += int'(bus.glitch_out);
      dones  += int'(bus.done);
      busys  += int'(bus.busy);
    end
  endtask

  task automatic monitor_starts(input int ncyc, output longint s0, output longint s1, output int dn);
    logic prev = 1'b0;
    s0 = -1; s1 = -1; dn = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (bus.glitch_out && !prev) begin
        if (s0 < 0) s0 = cyc;
        else if (s1 < 0) s1 = cyc;
      end
      prev = bus.glitch_out;
      dn += int'(bus.done);
    end
  endtask

  task automatic toggle_trig(input int times);
    repeat (times) begin
      repeat ($urandom_range(1, 15)) tick();
      bus.trig_in = ~bus.trig_in;
    end
  endtask

  vec_t   vecs[7];
  int     first, active, done_at, dn, busys;
  longint o, t, s0, s1, rd, rw, rg, rn, rp, per;
  bit     found, rfree;
  exp_t   e;

  initial begin
    vecs[0] = '{5, 3, 2, 3,  6, 9, 19, 3};
    vecs[1] = '{0, 0, 0, 2,  1, 2,  4, 2};
    vecs[2] = '{3, 1, 1, 0, -1, 0,  4, 0};
    vecs[3] = '{0, 1, 0, 1,  1, 1,  2, 1};
    vecs[4] = '{2, 4, 7, 2,  3, 8, 18, 2};
    vecs[5] = '{10, 2, 3, 4, 11, 8, 28, 4};
    vecs[6] = '{0, 0, 0, 0, -1, 0,  1, 0};

    rst = 1'b1;
    bus.arm = 1'b0; bus.free_run = 1'b0; bus.abort = 1'b0; bus.trig_in = 1'b0;
    bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0;
    bus.cfg_period = '0; bus.cfg_count = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_glitch_out", bus.glitch_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_pulse_cnt", bus.pulse_cnt, 0);
    check("reset_inverted_idle_high", bus_n.glitch_out, 1);

    // Vector table: single-shot bursts, offsets measured from trig_rise.
    foreach (vecs[i]) begin
      go_idle();
      arm_cfg(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].n, 0, 1'b0);
      repeat (2) tick();
      bus.trig_in = 1'b1;
      t = cyc + SYNC + 1;
      first = -1; active = 0; done_at = -1; dn = 0;
      repeat (80) begin
        @(negedge clk);
        if (bus.glitch_out) begin
          active++;
          if (first < 0) first = int'(cyc - t);
        end
        if (bus.done) begin
          dn++;
          done_at = int'(cyc - t);
        end
      end
      check($sformatf("vec%0d_first_active", i), first, vecs[i].exp_first);
      check($sformatf("vec%0d_active_cycles", i), active, vecs[i].exp_active);
      check($sformatf("vec%0d_done_offset", i), done_at, vecs[i].exp_done_at);
      check($sformatf("vec%0d_done_count", i), dn, 1);
      check($sformatf("vec%0d_pulse_cnt", i), bus.pulse_cnt, vecs[i].exp_pcnt);
      check($sformatf("vec%0d_busy_after", i), bus.busy, 0);
    end

    run_single("single_d5_w3_g2_n3", 5, 3, 2, 3);

    // Async reset in the middle of the second pulse.
    go_idle();
    arm_cfg(0, 4, 2, 3, 0, 1'b0);
    repeat (2) tick();
    bus.trig_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.glitch_out && bus.pulse_cnt == 1) found = 1'b1;
    end
    check("rst_mid_pulse_reached", found, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_pulse_glitch_out", bus.glitch_out, 0);
    check("rst_mid_pulse_busy", bus.busy, 0);
    check("rst_mid_pulse_pulse_cnt", bus.pulse_cnt, 0);
    check("rst_mid_pulse_inverted", bus_n.glitch_out, 1);
    bus.trig_in = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Maximum width must not wrap: still active long after entry, then abort.
    go_idle();
    arm_cfg(0, 64'hFFFF_FFFF, 1, 1, 0, 1'b0);
    repeat (2) tick();
    bus.trig_in = 1'b1;
    repeat (SYNC + 2) tick();
    count_quiet(150, active, dn, busys);
    check("max_width_active_cycles", active, 150);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("max_width_abort_out", bus.glitch_out, 0);
    check("max_width_abort_busy", bus.busy, 0);

    // Maximum gap, abort during it: pulse count holds.
    go_idle();
    arm_cfg(0, 2, 64'hFFFF_FFFF, 2, 0, 1'b0);
    repeat (2) tick();
    bus.trig_in = 1'b1;
    repeat (SYNC + 5) tick();
    count_quiet(120, active, dn, busys);
    check("max_gap_quiet", active + dn, 0);
    check("max_gap_busy", busys, 120);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    count_quiet(5, active, dn, busys);
    check("abort_gap_no_done", dn + busys + active, 0);
    check("abort_gap_pulse_cnt_holds", bus.pulse_cnt, 1);

    // Trigger already high at arm: wait for a fresh edge.
    go_idle();
    bus.trig_in = 1'b1;
    repeat (5) tick();
    arm_cfg(2, 2, 1, 1, 0, 1'b0);
    count_quiet(12, active, dn, busys);
    check("trig_high_at_arm_no_burst", active + dn, 0);
    check("trig_high_at_arm_still_armed", busys, 12);
    bus.trig_in = 1'b0;
    repeat (3) tick();
    bus.trig_in = 1'b1;
    o = cyc + SYNC + 2;
    check_window("trig_fresh_edge_burst", o, 2, 2, 1, 1, 0, 1'b0, int'(SYNC + 2 + 2 + 2 + 4));

    // Second trigger edge during GAP is ignored and not queued.
    go_idle();
    arm_cfg(1, 2, 6, 2, 0, 1'b0);
    repeat (2) tick();
    bus.trig_in = 1'b1;
    o = cyc + SYNC + 2;
    fork
      check_window("gap_edge_ignored", o, 1, 2, 6, 2, 0, 1'b0, 30);
      begin
        repeat (4) tick();
        bus.trig_in = 1'b0;
        repeat (4) tick();
        bus.trig_in = 1'b1;
      end
    join

    // Abort during DELAY.
    go_idle();
    arm_cfg(20, 3, 1, 2, 0, 1'b0);
    repeat (2) tick();
    bus.trig_in = 1'b1;
    repeat (SYNC + 6) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    count_quiet(40, active, dn, busys);
    check("abort_delay_no_pulse", active, 0);
    check("abort_delay_no_done", dn, 0);
    check("abort_delay_idle", busys, 0);

    // Abort in the same cycle as arm, both modes.
    for (int f = 0; f < 2; f++) begin
      go_idle();
      bus.cfg_delay = '0; bus.cfg_width = CNT_W'(2); bus.cfg_count = NUM_W'(1);
      bus.cfg_period = CNT_W'(3); bus.free_run = f[0];
      bus.arm = 1'b1; bus.abort = 1'b1;
      tick();
      bus.arm = 1'b0; bus.abort = 1'b0;
      bus.trig_in = 1'b1;
      count_quiet(15, active, dn, busys);
      check($sformatf("abort_with_arm_f%0d", f), active + dn + busys, 0);
    end

    // Free-run: 36-cycle pulses every 1038 cycles, trigger activity ignored.
    go_idle();
    arm_cfg(0, 36, 0, 1, 1000, 1'b1);
    o = cyc;
    fork
      check_window("freerun_w36_p1000", o, 0, 36, 0, 1, 1000, 1'b1, 3 * 1038 + 50);
      monitor_starts(3 * 1038 + 50, s0, s1, dn);
      toggle_trig(200);
    join
    check("freerun_start_spacing", s1 - s0, 1038);
    check("freerun_done_count", dn, 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("freerun_abort_busy", bus.busy, 0);
    check("freerun_abort_pulse_cnt", bus.pulse_cnt, 1);

    // Randomised bursts against the timeline model.
    for (int i = 0; i < 16; i++) begin
      rfree = 1'($urandom_range(0, 1));
      rd = $urandom_range(0, 6); rw = $urandom_range(0, 5); rg = $urandom_range(0, 4);
      rn = $urandom_range(0, 4); rp = $urandom_range(0, 8);
      if (!rfree) begin
        run_single($sformatf("rand%0d_single", i), rd, rw, rg, rn);
      end else begin
        go_idle();
        arm_cfg(rd, rw, rg, rn, rp, 1'b1);
        o = cyc;
        per = ((rd == 0) ? 1 : rd) + burst_len(rw, rg, rn) + 1 + ((rp == 0) ? 1 : rp);
        fork
          check_window($sformatf("rand%0d_free", i), o, rd, rw, rg, rn, rp, 1'b1, int'(3 * per + 5));
          toggle_trig(5);
        join
        e = model(cyc - o, rd, rw, rg, rn, rp, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        check($sformatf("rand%0d_abort_idle", i), {bus.busy, bus.glitch_out, bus.done}, 0);
        check($sformatf("rand%0d_abort_pcnt_hold", i), bus.pulse_cnt, e.pcnt);
      end
    end

    go_idle();
    check("inverted_build_mirror_mismatches", mirror_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Parametrised successor to the fixed-timing icestick glitch pulser.
- Produces a programmable burst of glitch pulses on one output pin, configured by delay, width, gap, count and period, all latched at arm time.
- Each burst starts either on a synchronised external trigger edge (single-shot) or periodically and autonomously (free-run).
- Sits between the target's trigger line and the crowbar/glitch driver pin.

Parameters:
- CNT_W, 32, width of the delay, width, gap and period counters and their config inputs.
- NUM_W, 8, width of the pulse-count config and of pulse_cnt.
- ACTIVE_HIGH, 1: 1 means glitch_out is high during a pulse; 0 means the output is inverted (idle high).
- SYNC_STAGES, 2, number of synchroniser flops on trig_in (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- arm  in  1  level; sampled in IDLE to latch config and start
- free_run  in  1  mode select, latched with arm: 0 = single-shot on trigger, 1 = periodic
- abort  in  1  level; forces return to IDLE
- trig_in  in  1  asynchronous external trigger; rising edge is significant
- cfg_delay  in  CNT_W  cycles from trigger to first pulse
- cfg_width  in  CNT_W  active cycles per pulse; 0 is treated as 1
- cfg_gap  in  CNT_W  inactive cycles between pulses; 0 is treated as 1
- cfg_count  in  NUM_W  pulses per burst
- cfg_period  in  CNT_W  free-run: inactive cycles after a burst before the next burst starts; 0 is treated as 1
- glitch_out  out  1  registered glitch drive
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of each burst
- pulse_cnt  out  NUM_W  pulses completed in the current burst

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE; all counters and sync flops cleared; shadow config cleared.
  - busy = 0, done = 0, pulse_cnt = 0.
  - glitch_out = inactive level (0 if ACTIVE_HIGH, otherwise 1).
- Trigger path:
  - trig_in passes through SYNC_STAGES flops, then a rising-edge detector, giving a one-cycle trig_rise.
  - The detector runs in every state.
  - If trig_in is already high when arming, no edge is seen, so the block waits for a fresh low-to-high transition.
- IDLE:
  - On arm=1 and abort=0, latch all cfg_* and free_run into shadow registers; go to ARMED (free_run=0) or DELAY (free_run=1) on the next edge.
  - Config inputs are ignored outside this latch point.
- ARMED: on trig_rise, go to DELAY; pulse_cnt is cleared to 0.
- DELAY:
  - Stays for exactly cfg_delay cycles.
  - cfg_delay=0 means PULSE is entered on the cycle after trig_rise.
  - glitch_out goes active on the first PULSE cycle, i.e. cfg_delay+1 cycles after trig_rise.
- PULSE:
  - glitch_out is active for exactly max(cfg_width,1) cycles.
  - On exit, pulse_cnt increments.
  - If pulse_cnt+1 < cfg_count, go to GAP; otherwise go to END.
- GAP: glitch_out inactive for max(cfg_gap,1) cycles, then PULSE.
- cfg_count=0: DELAY is still timed, then the block goes directly to END with no pulse; pulse_cnt stays 0.
- END (one cycle):
  - done = 1 for this cycle; glitch_out inactive.
  - Single-shot: go to IDLE.
  - Free-run: go to HOLD.
- HOLD (free-run only): inactive for max(cfg_period,1) cycles, then clear pulse_cnt and go to DELAY. This repeats indefinitely until abort.
- Free-run ignores trig_in entirely.
- abort=1 in any state:
  - Next edge: state = IDLE, glitch_out inactive, done not pulsed, pulse_cnt holds its value.
  - abort has priority over arm in the same cycle.
- Edges on trig_rise outside ARMED are ignored and not queued.
- Deasserting arm mid-burst has no effect.
- Counters:
  - Down-counters are loaded with the value minus 1 on state entry.
  - All arithmetic is unsigned, CNT_W wide.
  - Maximum values (2^CNT_W−1) are legal and must not wrap early.
- Latency bookkeeping for the bench: trig_in high to trig_rise = SYNC_STAGES+1 cycles.

Test Plan:
- Reset mid-PULSE (rst asserted asynchronously) -> glitch_out = inactive level before the next clk edge; busy=0; pulse_cnt=0; state IDLE.
- Single-shot, delay=5, width=3, gap=2, count=3; trig_in rises -> first active cycle exactly 6 cycles after trig_rise; pattern 3 on / 2 off / 3 on / 2 off / 3 on; done one cycle after the last active cycle; pulse_cnt=3; back to IDLE.
- Free-run, delay=0, width=36, count=1, period=1000 -> 36-cycle pulses with a start-to-start spacing of 1+36+1+1000; trig_in toggling has no effect; done pulses once per burst.
- width=0, gap=0, count=2 -> pulses of 1 cycle each separated by 1 inactive cycle; count=0 -> no active cycle, done after the delay.
- trig_in held high before arm, then armed -> no burst; trig_in low then high -> burst starts; a second trig edge during GAP is ignored.
- abort asserted during DELAY, and again in the same cycle as arm -> immediate IDLE, no pulse, no done; ACTIVE_HIGH=0 build idles high throughout.
